// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions for the instruction-side blocks: base opcodes,
// datapath width, canonical NOP and the fetch FSM state encoding.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

    localparam logic [6:0] OPC_R       = 7'h33;
    localparam logic [6:0] OPC_I_LOGIC = 7'h13;
    localparam logic [6:0] OPC_U       = 7'h37;
    localparam logic [6:0] OPC_LOAD    = 7'h03;
    localparam logic [6:0] OPC_STORE   = 7'h23;
    localparam logic [6:0] OPC_BRANCH  = 7'h63;
    localparam logic [6:0] OPC_JALR    = 7'h67;
    localparam logic [6:0] OPC_JAL     = 7'h6F;

    typedef enum logic [1:0] {
        FS_BOOT  = 2'd0,
        FS_FETCH = 2'd1,
        FS_HOLD  = 2'd2
    } fetch_state_e;

    // True when the word carries one of the opcodes the control decoder handles.
    function automatic logic opcode_legal(input logic [XLEN-1:0] instr);
        logic [6:0] opc;
        opc = instr[6:0];
        return (instr[1:0] == 2'b11) &&
               (opc inside {OPC_R, OPC_I_LOGIC, OPC_U, OPC_LOAD,
                            OPC_STORE, OPC_BRANCH, OPC_JALR, OPC_JAL});
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO used for the fetch prefetch buffer and the
// outstanding-request PC tags. Push while full is accepted when a pop
// happens in the same cycle. Flush empties the FIFO and ignores push/pop.
module fetch_fifo #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 2,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty     = (count == '0);
    assign full      = (count == CW'(DEPTH));
    assign do_pop    = pop && !empty;
    assign do_push   = push && (!full || do_pop);
    assign head_data = mem[rd_ptr];

    // Storage, pointers and occupancy; pointers wrap naturally (DEPTH is a power of 2).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues word fetches over req/gnt/rvalid,
// buffers responses and hands {instruction, PC} to decode over valid/ready.
// Redirects flush the buffer and discard responses still in flight.
// Optional feature macro: FETCH_OPCODE_CHECK_EN (flags unknown opcodes on Illegal_o).
//
// state    | meaning
// ---------+-------------------------------------------------------------
// FS_BOOT  | first cycle after reset, no request issued
// FS_FETCH | requesting while outstanding + buffered < FIFO_DEPTH
// FS_HOLD  | all credits in use, request low until a pop or a drop
module instr_fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0040_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Redirect_i,
    input  logic [31:0] Redirect_PC_i,
    output logic        Imem_Req_o,
    output logic [31:0] Imem_Addr_o,
    input  logic        Imem_Gnt_i,
    input  logic        Imem_Rvalid_i,
    input  logic [31:0] Imem_Rdata_i,
    output logic        Instr_Valid_o,
    input  logic        Instr_Ready_i,
    output logic [31:0] Instr_o,
    output logic [31:0] PC_o,
    output logic        Illegal_o
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(FIFO_DEPTH);
`ifdef FETCH_OPCODE_CHECK_EN
    localparam int ENTRY_W = 2 * XLEN + 1;
`else
    localparam int ENTRY_W = 2 * XLEN;
`endif

    fetch_state_e     state_q;
    fetch_state_e     state_d;
    logic [XLEN-1:0]  pc_q;
    logic [CW-1:0]    drop_q;
    logic [CW-1:0]    outst;
    logic [CW-1:0]    fifo_count;
    logic             grant;
    logic             push_fifo;
    logic             pop_fifo;
    logic             tag_pop;
    logic             credit_ok;
    logic             data_full;
    logic             data_empty;
    logic             tag_full;
    logic             tag_empty;
    logic [CW:0]      total_now;
    logic [CW:0]      outst_next;
    logic [CW:0]      fifo_next;
    logic [CW:0]      total_next;
    logic [XLEN-1:0]  tag_pc;
    logic [ENTRY_W-1:0] push_entry;
    logic [ENTRY_W-1:0] head_entry;

    assign total_now = {1'b0, outst} + {1'b0, fifo_count};
    assign credit_ok = (total_now < DEPTH_W) && !data_full && !tag_full;

    // A redirect cycle never requests, so no grant can race the PC reload.
    assign Imem_Req_o  = (state_q == FS_FETCH) && credit_ok && !Redirect_i;
    assign Imem_Addr_o = pc_q;
    assign grant       = Imem_Req_o && Imem_Gnt_i;

    // Responses owed to a pre-redirect PC stream are dropped, including one arriving on the redirect cycle.
    assign push_fifo = Imem_Rvalid_i && (drop_q == '0) && !Redirect_i;
    assign pop_fifo  = Instr_Valid_o && Instr_Ready_i && !Redirect_i;
    assign tag_pop   = Imem_Rvalid_i && !tag_empty;

    assign outst_next = {1'b0, outst} + (CW + 1)'(grant) - (CW + 1)'(Imem_Rvalid_i);
    assign fifo_next  = Redirect_i ? '0
                      : {1'b0, fifo_count} + (CW + 1)'(push_fifo) - (CW + 1)'(pop_fifo);
    assign total_next = outst_next + fifo_next;

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= FS_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: park in HOLD while every credit is committed; a redirect always restarts fetch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FS_BOOT:  state_d = FS_FETCH;
            FS_FETCH: if (total_next >= DEPTH_W) state_d = FS_HOLD;
            FS_HOLD:  if (total_next < DEPTH_W) state_d = FS_FETCH;
            default:  state_d = FS_BOOT;
        endcase
        if (Redirect_i) begin
            state_d = FS_FETCH;
        end
    end

    // PC and drop counter; on redirect everything still in flight becomes a drop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q   <= RESET_PC;
            drop_q <= '0;
        end else if (Redirect_i) begin
            pc_q   <= Redirect_PC_i & ~32'h3;
            drop_q <= outst - CW'(Imem_Rvalid_i);
        end else begin
            if (grant) begin
                pc_q <= pc_q + 32'd4;
            end
            if (Imem_Rvalid_i && (drop_q != '0)) begin
                drop_q <= drop_q - CW'(1);
            end
        end
    end

`ifdef FETCH_OPCODE_CHECK_EN
    assign push_entry = {~opcode_legal(Imem_Rdata_i), tag_pc, Imem_Rdata_i};
    assign Illegal_o  = Instr_Valid_o && head_entry[2*XLEN];
`else
    assign push_entry = {tag_pc, Imem_Rdata_i};
    assign Illegal_o  = 1'b0;
`endif

    // PC tags follow requests in order; tag occupancy is the outstanding count.
    fetch_fifo #(
        .WIDTH (XLEN),
        .DEPTH (FIFO_DEPTH)
    ) u_tag_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (grant),
        .push_data (pc_q),
        .pop       (tag_pop),
        .flush     (1'b0),
        .head_data (tag_pc),
        .full      (tag_full),
        .empty     (tag_empty),
        .count     (outst)
    );

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_data_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_fifo),
        .push_data (push_entry),
        .pop       (pop_fifo),
        .flush     (Redirect_i),
        .head_data (head_entry),
        .full      (data_full),
        .empty     (data_empty),
        .count     (fifo_count)
    );

    assign Instr_Valid_o = !data_empty;
    assign Instr_o       = head_entry[XLEN-1:0];
    assign PC_o          = head_entry[2*XLEN-1:XLEN];

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0040_0000;
    localparam int          DEPTH    = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        Redirect_i = 1'b0;
    logic [31:0] Redirect_PC_i = '0;
    logic        Imem_Req_o;
    logic [31:0] Imem_Addr_o;
    logic        Imem_Gnt_i = 1'b0;
    logic        Imem_Rvalid_i = 1'b0;
    logic [31:0] Imem_Rdata_i = '0;
    logic        Instr_Valid_o;
    logic        Instr_Ready_i = 1'b0;
    logic [31:0] Instr_o;
    logic [31:0] PC_o;
    logic        Illegal_o;

    instr_fetch_unit dut (
        .clk           (clk),
        .reset         (reset),
        .Redirect_i    (Redirect_i),
        .Redirect_PC_i (Redirect_PC_i),
        .Imem_Req_o    (Imem_Req_o),
        .Imem_Addr_o   (Imem_Addr_o),
        .Imem_Gnt_i    (Imem_Gnt_i),
        .Imem_Rvalid_i (Imem_Rvalid_i),
        .Imem_Rdata_i  (Imem_Rdata_i),
        .Instr_Valid_o (Instr_Valid_o),
        .Instr_Ready_i (Instr_Ready_i),
        .Instr_o       (Instr_o),
        .PC_o          (PC_o),
        .Illegal_o     (Illegal_o)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int compared   = 0;
    int mismatched = 0;
    int delivered  = 0;

    // Stimulus knobs (percent probabilities).
    int p_gnt = 100, p_rvalid = 100, p_ready = 100, p_redir = 0;
    bit          force_redir = 0;
    logic [31:0] force_target = '0;

    // Reference model: memory image, fetches in flight, words the decode side must see next.
    typedef struct {
        logic [31:0] pc;
        bit          stale;
    } fl_t;
    fl_t         inflight[$];
    logic [63:0] exp_q[$];
    logic [31:0] exp_fetch_pc;
    bit          boot;
    logic [31:0] mem_ovr [logic [31:0]];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (mem_ovr.exists(a)) return mem_ovr[a];
        return (a * 32'h9E37_79B1) + 32'h0000_0013;
    endfunction

    function automatic bit is_illegal(input logic [31:0] w);
        logic [6:0] op;
        op = w[6:0];
        return (w[1:0] != 2'b11) ||
               !(op inside {7'h33, 7'h13, 7'h37, 7'h03, 7'h23, 7'h63, 7'h67, 7'h6F});
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rand_target();
        case ($urandom_range(3))
            0:       return RESET_PC + ($urandom_range(255) << 2) + $urandom_range(3);
            1:       return 32'hFFFF_FFF0 + $urandom_range(15);
            2:       return $urandom;
            default: return RESET_PC;
        endcase
    endfunction

    task automatic drive();
        Imem_Gnt_i = ($urandom_range(99) < p_gnt);
        if (inflight.size() != 0 && $urandom_range(99) < p_rvalid) begin
            Imem_Rvalid_i = 1'b1;
            Imem_Rdata_i  = mem_word(inflight[0].pc);
        end else begin
            Imem_Rvalid_i = 1'b0;
            Imem_Rdata_i  = $urandom;
        end
        Instr_Ready_i = ($urandom_range(99) < p_ready);
        if (force_redir) begin
            Redirect_i    = 1'b1;
            Redirect_PC_i = force_target;
            force_redir   = 0;
        end else if ($urandom_range(99) < p_redir) begin
            Redirect_i    = 1'b1;
            Redirect_PC_i = rand_target();
        end else begin
            Redirect_i    = 1'b0;
            Redirect_PC_i = $urandom;
        end
    endtask

    // Called at the falling edge: compare outputs, then advance the model across the coming rising edge.
    task automatic check_update();
        bit  exp_valid;
        bit  exp_req;
        bit  exp_ill;
        fl_t fl;
        exp_valid = (exp_q.size() != 0);
        exp_req   = !boot && !Redirect_i && ((inflight.size() + exp_q.size()) < DEPTH);
        chk("valid", Instr_Valid_o, exp_valid);
        if (exp_valid && Instr_Valid_o) begin
            chk("pc_o", PC_o, exp_q[0][63:32]);
            chk("instr_o", Instr_o, exp_q[0][31:0]);
        end
        chk("req", Imem_Req_o, exp_req);
        if (exp_req && Imem_Req_o) chk("addr", Imem_Addr_o, exp_fetch_pc);
        exp_ill = 0;
`ifdef FETCH_OPCODE_CHECK_EN
        if (exp_valid) exp_ill = is_illegal(exp_q[0][31:0]);
`endif
        chk("illegal", Illegal_o, exp_ill);

        if (Redirect_i) begin
            exp_q.delete();
            foreach (inflight[i]) inflight[i].stale = 1;
            if (Imem_Rvalid_i) fl = inflight.pop_front();
            exp_fetch_pc = Redirect_PC_i & ~32'h3;
        end else begin
            if (exp_valid && Instr_Ready_i) begin
                void'(exp_q.pop_front());
                delivered++;
            end
            if (Imem_Rvalid_i) begin
                fl = inflight.pop_front();
                if (!fl.stale) exp_q.push_back({fl.pc, mem_word(fl.pc)});
            end
            if (Imem_Req_o && Imem_Gnt_i) begin
                inflight.push_back('{exp_fetch_pc, 1'b0});
                exp_fetch_pc = exp_fetch_pc + 32'd4;
            end
        end
        boot = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drive();
        @(negedge clk);
        check_update();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        Redirect_i = 1'b0; Imem_Gnt_i = 1'b0; Imem_Rvalid_i = 1'b0; Instr_Ready_i = 1'b0;
        inflight.delete();
        exp_q.delete();
        exp_fetch_pc = RESET_PC;
        boot = 1;
        force_redir = 0;
        @(negedge clk);
        chk("rst_req", Imem_Req_o, 1'b0);
        chk("rst_addr", Imem_Addr_o, RESET_PC);
        chk("rst_valid", Instr_Valid_o, 1'b0);
        chk("rst_instr", Instr_o, 32'h0);
        chk("rst_pc", PC_o, 32'h0);
        chk("rst_illegal", Illegal_o, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        drive();
        @(negedge clk);
        check_update();
    endtask

    task automatic wait_valid(input string name, input int budget);
        int n = 0;
        while (!Instr_Valid_o && n < budget) begin
            step();
            n++;
        end
        chk({name, "_valid_wait"}, Instr_Valid_o, 1'b1);
    endtask

    task automatic wait_req(input string name, input int budget);
        int n = 0;
        while (!Imem_Req_o && n < budget) begin
            step();
            n++;
        end
        chk({name, "_req_wait"}, Imem_Req_o, 1'b1);
    endtask

    initial begin
        int grants;

        // Boot, first fetch, prefetch limit with decode stalled.
        mem_ovr[RESET_PC] = 32'h0050_0093;
        p_gnt = 100; p_rvalid = 100; p_ready = 0; p_redir = 0;
        do_reset();
        chk("t1_boot_req", Imem_Req_o, 1'b0);
        grants = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (i == 0) begin
                chk("t1_first_req", Imem_Req_o, 1'b1);
                chk("t1_first_addr", Imem_Addr_o, 32'h0040_0000);
            end
            if (Imem_Req_o && Imem_Gnt_i) grants++;
        end
        chk("t2_grants", grants, 2);
        chk("t2_req_held_low", Imem_Req_o, 1'b0);
        chk("t1_valid", Instr_Valid_o, 1'b1);
        chk("t1_pc", PC_o, 32'h0040_0000);
        chk("t1_instr", Instr_o, 32'h0050_0093);
        p_ready = 100;
        wait_req("t2", 10);
        chk("t2_resume_addr", Imem_Addr_o, 32'h0040_0008);

        // Grant stall holds request and address.
        do_reset();
        step();
        p_gnt = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t3_req_stall", Imem_Req_o, 1'b1);
            chk("t3_addr_stall", Imem_Addr_o, 32'h0040_0004);
        end
        p_gnt = 100;
        step();
        chk("t3_addr_grant", Imem_Addr_o, 32'h0040_0004);
        step();
        chk("t3_addr_next", Imem_Addr_o, 32'h0040_0008);

        // Redirect with two fetches outstanding.
        p_rvalid = 0;
        do_reset();
        step();
        step();
        force_redir = 1; force_target = 32'h0040_0103;
        step();
        chk("t4_redir_req", Imem_Req_o, 1'b0);
        p_rvalid = 100;
        wait_req("t4", 20);
        chk("t4_new_addr", Imem_Addr_o, 32'h0040_0100);
        wait_valid("t4", 20);
        chk("t4_first_pc", PC_o, 32'h0040_0100);

        // Redirect coincident with a response.
        p_rvalid = 0;
        do_reset();
        step();
        step();
        p_rvalid = 100;
        force_redir = 1; force_target = 32'h0040_0200;
        step();
        chk("t5_rvalid_on_redir", Imem_Rvalid_i, 1'b1);
        step();
        chk("t5_no_stale_valid", Instr_Valid_o, 1'b0);
        wait_valid("t5", 20);
        chk("t5_first_pc", PC_o, 32'h0040_0200);

        // Opcode check.
        mem_ovr[RESET_PC]         = 32'h0000_0073;
        mem_ovr[RESET_PC + 32'd4] = 32'h0000_006F;
        p_ready = 0;
        do_reset();
        wait_valid("t6", 10);
        repeat (3) step();
        chk("t6_instr_73", Instr_o, 32'h0000_0073);
`ifdef FETCH_OPCODE_CHECK_EN
        chk("t6_ill_73", Illegal_o, 1'b1);
`else
        chk("t6_ill_73", Illegal_o, 1'b0);
`endif
        p_ready = 100;
        step();
        p_ready = 0;
        step();
        chk("t6_instr_6f", Instr_o, 32'h0000_006F);
        chk("t6_pc_6f", PC_o, 32'h0040_0004);
        chk("t6_ill_6f", Illegal_o, 1'b0);
        mem_ovr.delete();

        // Randomized traffic with an asynchronous reset mid-burst.
        p_ready = 100;
        do_reset();
        delivered = 0;
        for (int c = 0; c < 3000; c++) begin
            if (c % 250 == 0) begin
                p_gnt    = $urandom_range(100, 30);
                p_rvalid = $urandom_range(100, 30);
                p_ready  = $urandom_range(100, 20);
                p_redir  = $urandom_range(10);
            end
            if (c == 1500) begin
                @(posedge clk);
                #2;
                reset = 1'b0;
                #1;
                chk("t5_async_req", Imem_Req_o, 1'b0);
                chk("t5_async_valid", Instr_Valid_o, 1'b0);
                chk("t5_async_pc", PC_o, 32'h0);
                chk("t5_async_instr", Instr_o, 32'h0);
                do_reset();
            end
            step();
        end
        compared++;
        if (delivered < 100) begin
            mismatched++;
            $display("FAIL progress: delivered %0d instructions, required at least 100", delivered);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
